uart_tx_arbiter: RTL and testbench

- Shares one UART byte transmitter (uart_control TX path) between NUM_REQ requesters, e.g. ADC report, key-event report and string handler.
- Arbitrates round-robin at packet boundaries. Streams the granted requester's bytes through a tx_start/tx_busy handshake.
- Aborts a packet if the requester stalls mid-packet.

---
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART byte transmitter.
// Optional header byte before each packet when UART_ARB_HDR_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 pkt_done,
  output logic                 pkt_abort
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT_CYC - 1);

`ifdef UART_ARB_HDR_EN
  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, HDR} state_t;
`else
  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
`endif

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [IDX_W-1:0]   g_idx, g_idx_n, rr_ptr, rr_n, rr_next, win_idx;
  logic [7:0]         tx_data_n, sel_data;
  logic               tx_start_n, done_n, abort_n, last_f, last_n;
  logic [CNT_W-1:0]   stall_cnt, cnt_n;
  logic               found, sel_valid, sel_last, xfer;
  logic [SUM_W-1:0]   cand;

  // First valid requester at or after the rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) cand = cand - SUM_W'(NUM_REQ);
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_valid = req_valid[g_idx];
    sel_last  = req_last[g_idx];
    sel_data  = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (g_idx == IDX_W'(k)) sel_data = req_data[8*k +: 8];
    end
  end

  assign rr_next = (g_idx == LAST_IDX) ? '0 : g_idx + IDX_W'(1);
  assign xfer    = (state == SEND) && sel_valid && !tx_busy;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[g_idx] = 1'b1;
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    g_idx_n    = g_idx;
    rr_n       = rr_ptr;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
    done_n     = 1'b0;
    abort_n    = 1'b0;
    last_n     = last_f;
    cnt_n      = stall_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n          = '0;
          grant_n[win_idx] = 1'b1;
          g_idx_n          = win_idx;
          cnt_n            = '0;
`ifdef UART_ARB_HDR_EN
          state_n          = HDR;
`else
          state_n          = SEND;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      HDR: begin
        tx_data_n  = {4'hA, 1'b0, 3'(g_idx)};
        tx_start_n = 1'b1;
        last_n     = 1'b0;
        state_n    = WAIT_HI;
      end
`endif
      SEND: begin
        if (xfer) begin
          tx_data_n  = sel_data;
          tx_start_n = 1'b1;
          last_n     = sel_last;
          cnt_n      = '0;
          state_n    = WAIT_HI;
        end else if (!sel_valid) begin
          if (stall_cnt == STALL_MAX) begin
            abort_n = 1'b1;
            grant_n = '0;
            rr_n    = rr_next;
            cnt_n   = '0;
            state_n = IDLE;
          end else if (stall_cnt != '1) begin
            cnt_n = stall_cnt + CNT_W'(1);
          end
        end
      end
      WAIT_HI: begin
        if (tx_busy) state_n = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_f) begin
            done_n  = 1'b1;
            grant_n = '0;
            rr_n    = rr_next;
            state_n = IDLE;
          end else begin
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      grant     <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      last_f    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      g_idx     <= g_idx_n;
      rr_ptr    <= rr_n;
      tx_data   <= tx_data_n;
      tx_start  <= tx_start_n;
      pkt_done  <= done_n;
      pkt_abort <= abort_n;
      last_f    <= last_n;
      stall_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter (3 requesters, TIMEOUT_CYC=16).
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           sys_rst = 1'b1;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_start, tx_busy, pkt_done, pkt_abort;
  logic           ext_busy = 1'b0;
  int             xmt_cnt = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .pkt_done(pkt_done), .pkt_abort(pkt_abort)
  );

  // Transmitter: busy for a random 1..6 cycle frame after each start pulse.
  assign tx_busy = ext_busy || (xmt_cnt != 0);
  always @(posedge clk) begin
    if (sys_rst) xmt_cnt <= 0;
    else if (tx_start) xmt_cnt <= $urandom_range(1, 6);
    else if (xmt_cnt != 0) xmt_cnt <= xmt_cnt - 1;
  end

  int total = 0, bad = 0;
  logic [9:0]  src_q [N][$];  // {first, last, byte}
  logic [9:0]  mq [N][$];
  logic [10:0] tx_log[$], exp_log[$];  // {grant, byte}
  logic [2:0]  grant_log[$];
  int          done_n = 0, abort_n = 0, abort_dist = 0, start_busy = 0, cyc = 0, fall_cyc = 0;
  logic [2:0]  grant_at_abort = 3'b111, prev_grant = 3'b000;
  logic        prev_busy = 1'b0;
  bit          rnd_gaps = 1'b0;
  int          gap_run [N];
  logic [N-1:0] acc;

  typedef struct {
    logic [2:0] mask;
    logic [2:0] order [3];
    int         n;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int oh2i(input logic [2:0] g);
    return g[1] ? 1 : (g[2] ? 2 : 0);
  endfunction

  // Requester driver: pops bytes the arbiter accepted last cycle, may gap mid-packet.
  initial begin
    logic [9:0] head;
    bit stall;
    req_valid = '0; req_data = '0; req_last = '0; acc = '0;
    for (int i = 0; i < N; i++) gap_run[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < N; i++) begin
        req_valid[i] = 1'b0; req_last[i] = 1'b0; req_data[8*i +: 8] = 8'h00;
        if (src_q[i].size() > 0) begin
          head  = src_q[i][0];
          stall = rnd_gaps && !head[9] && gap_run[i] < 5 && ($urandom_range(0, 3) == 0);
          gap_run[i] = stall ? gap_run[i] + 1 : 0;
          req_valid[i] = !stall;
          req_last[i]  = head[8];
          req_data[8*i +: 8] = head[7:0];
        end
      end
      #1;
      acc = req_ready & req_valid & {N{!sys_rst}};
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (tx_start) begin
        tx_log.push_back({grant, tx_data});
        if (tx_busy) start_busy++;
      end
      if (pkt_done) done_n++;
      if (pkt_abort) begin
        abort_n++;
        abort_dist     = cyc - fall_cyc;
        grant_at_abort = grant;
      end
      if (prev_busy && !tx_busy) fall_cyc = cyc;
      prev_busy = tx_busy;
      if (grant != 3'b000 && grant != prev_grant) grant_log.push_back(grant);
      prev_grant = grant;
    end
  end

  task automatic post_pkt(input int r, input int len, input logic [7:0] base, input bit with_last);
    for (int k = 0; k < len; k++)
      src_q[r].push_back({k == 0, with_last && (k == len - 1), base + 8'(k)});
  endtask

  task automatic exp_hdr(input int r);
`ifdef UART_ARB_HDR_EN
    exp_log.push_back({3'(1 << r), 4'hA, 1'b0, 3'(r)});
`endif
  endtask

  task automatic exp_pkt(input int r, input int len, input logic [7:0] base);
    exp_hdr(r);
    for (int k = 0; k < len; k++) exp_log.push_back({3'(1 << r), base + 8'(k)});
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, tx_log.size(), exp_log.size());
    for (int i = 0; i < tx_log.size() && i < exp_log.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), tx_log[i], exp_log[i]);
    tx_log.delete();
    exp_log.delete();
  endtask

  task automatic wait_idle(input string name);
    int  n;
    bit  ok;
    n = 0; ok = 1'b0;
    while (n < 5000 && !ok) begin
      @(negedge clk); #3; n++;
      ok = all_empty() && grant == 3'b000 && !tx_busy;
    end
    chk({name, "_idle"}, ok, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_grant(input logic [2:0] g, input string name);
    int n;
    n = 0;
    while (n < 500 && grant !== g) begin
      @(negedge clk); #3; n++;
    end
    chk({name, "_grant"}, grant, g);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sys_rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    tx_log.delete(); exp_log.delete(); grant_log.delete();
    done_n = 0; abort_n = 0; start_busy = 0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int any_ready, npk, len, rr;
    logic [9:0] e;
    // Hand-derived round-robin order; rr carries over from one entry to the next.
    vecs[0] = '{mask: 3'b111, order: '{3'b001, 3'b010, 3'b100}, n: 3};
    vecs[1] = '{mask: 3'b010, order: '{3'b010, 3'b000, 3'b000}, n: 1};
    vecs[2] = '{mask: 3'b101, order: '{3'b100, 3'b001, 3'b000}, n: 2};
    vecs[3] = '{mask: 3'b101, order: '{3'b100, 3'b001, 3'b000}, n: 2};
    vecs[4] = '{mask: 3'b001, order: '{3'b001, 3'b000, 3'b000}, n: 1};
    vecs[5] = '{mask: 3'b011, order: '{3'b010, 3'b001, 3'b000}, n: 2};
    vecs[6] = '{mask: 3'b100, order: '{3'b100, 3'b000, 3'b000}, n: 1};
    vecs[7] = '{mask: 3'b101, order: '{3'b001, 3'b100, 3'b000}, n: 2};

    src_q[0].push_back({1'b1, 1'b0, 8'h11});
    src_q[0].push_back({1'b0, 1'b0, 8'h22});
    src_q[0].push_back({1'b0, 1'b1, 8'h33});
    repeat (3) @(negedge clk);
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_pkt_abort", pkt_abort, 0);
    chk("rst_req_ready", req_ready, 0);

    @(negedge clk);
    sys_rst = 1'b0;
    exp_hdr(0);
    exp_log.push_back({3'b001, 8'h11});
    exp_log.push_back({3'b001, 8'h22});
    exp_log.push_back({3'b001, 8'h33});
    wait_idle("single");
    check_log("single");
    chk("single_done", done_n, 1);
    chk("single_grant_end", grant, 0);
    chk("single_start_busy", start_busy, 0);

    do_reset();
    for (int v = 0; v < 8; v++) begin
      for (int r = 0; r < N; r++)
        if (vecs[v].mask[r]) post_pkt(r, 1, 8'h40 + 8'(v * 4 + r), 1'b1);
      for (int j = 0; j < vecs[v].n; j++)
        exp_pkt(oh2i(vecs[v].order[j]), 1, 8'h40 + 8'(v * 4 + oh2i(vecs[v].order[j])));
      wait_idle($sformatf("vec%0d", v));
      check_log($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_ngrant", v), grant_log.size(), vecs[v].n);
      for (int j = 0; j < vecs[v].n && j < grant_log.size(); j++)
        chk($sformatf("vec%0d_grant%0d", v, j), grant_log[j], vecs[v].order[j]);
      chk($sformatf("vec%0d_done", v), done_n, vecs[v].n);
      grant_log.delete();
      done_n = 0;
    end

    post_pkt(1, 4, 8'hB0, 1'b1);
    wait_grant(3'b010, "nopreempt");
    post_pkt(0, 1, 8'hC0, 1'b1);
    exp_pkt(1, 4, 8'hB0);
    exp_pkt(0, 1, 8'hC0);
    wait_idle("nopreempt");
    check_log("nopreempt");

    ext_busy = 1'b1;
    post_pkt(0, 1, 8'hD0, 1'b1);
    wait_grant(3'b001, "extbusy");
    any_ready = 0;
    repeat (4) begin
      @(negedge clk); #3;
      if (req_ready != 0) any_ready = 1;
    end
    chk("extbusy_ready_held", any_ready, 0);
    @(negedge clk);
    ext_busy = 1'b0;
    exp_pkt(0, 1, 8'hD0);
    wait_idle("extbusy");
    check_log("extbusy");

    do_reset();
    post_pkt(0, 1, 8'hE0, 1'b0);
    wait_idle("timeout");
    chk("timeout_aborts", abort_n, 1);
    // One cycle from busy-low to SEND, then TIMEOUT_CYC cycles in SEND.
    chk("timeout_delay", abort_dist, TO + 1);
    chk("timeout_grant", grant_at_abort, 0);
    chk("timeout_no_done", done_n, 0);
    post_pkt(1, 1, 8'hE1, 1'b1);
    exp_pkt(0, 1, 8'hE0);
    exp_pkt(1, 1, 8'hE1);
    wait_idle("after_abort");
    check_log("after_abort");
    chk("after_abort_done", done_n, 1);

    do_reset();
    post_pkt(2, 2, 8'h70, 1'b1);
    begin
      int n;
      n = 0;
      while (n < 200 && !tx_busy) begin
        @(negedge clk); #3; n++;
      end
      chk("midrst_busy_seen", tx_busy, 1);
    end
    @(negedge clk);
    sys_rst = 1'b1;
    src_q[2].delete();
    @(negedge clk); #3;
    chk("midrst_grant", grant, 0);
    chk("midrst_tx_start", tx_start, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_pkt_done", pkt_done, 0);
    chk("midrst_req_ready", req_ready, 0);
    @(negedge clk);
    sys_rst = 1'b0;
    tx_log.delete(); exp_log.delete(); done_n = 0;
    post_pkt(1, 1, 8'h5A, 1'b1);
    exp_pkt(1, 1, 8'h5A);
    wait_idle("midrst_after");
    check_log("midrst_after");
    chk("midrst_after_done", done_n, 1);

    for (int round = 0; round < 3; round++) begin
      do_reset();
      rnd_gaps = 1'b1;
      npk = 0;
      for (int r = 0; r < N; r++) begin
        for (int p = $urandom_range(1, 4); p > 0; p--) begin
          len = $urandom_range(1, 5);
          npk++;
          for (int k = 0; k < len; k++) begin
            e = {k == 0, k == len - 1, 8'($urandom)};
            src_q[r].push_back(e);
            mq[r].push_back(e);
          end
        end
      end
      // Reference: serve whole packets, next owner is first non-empty queue at/after rr.
      rr = 0;
      while (mq[0].size() + mq[1].size() + mq[2].size() > 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (rr + k) % N;
          if (mq[c].size() > 0) begin
            exp_hdr(c);
            do begin
              e = mq[c].pop_front();
              exp_log.push_back({3'(1 << c), e[7:0]});
            end while (!e[8]);
            rr = (c + 1) % N;
            break;
          end
        end
      end
      wait_idle($sformatf("rand%0d", round));
      check_log($sformatf("rand%0d", round));
      chk($sformatf("rand%0d_done", round), done_n, npk);
      chk($sformatf("rand%0d_aborts", round), abort_n, 0);
      rnd_gaps = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
